// File: rtl/debounce_botoes.sv
// Purpose : debounces N raw push-button pins and classifies accepted press,
//           release and long-press events, sampled on a divider tick.
// Latency : pins/tick pass 2 sync flops; outputs update on the clk edge that
//           ends the tick cycle deciding the transition.
// Backpr. : none; pulses are fire-and-forget, one clk cycle wide.
//
// Ports:
//   clk          board clock, the only clock in the block
//   reset        asynchronous, active-low reset
//   tick_in      button-rate tick from the clock divider (sampled as data)
//   botao[N]     raw button pins, asynchronous
//   nivel[N]     debounced level, 1 = pressed
//   pulso_press  one-cycle pulse on an accepted press
//   pulso_solta  one-cycle pulse on an accepted release
//   pulso_longo  one-cycle pulse once per press after LONG_TICKS held ticks

module debounce_botoes #(
    parameter int N            = 4,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_in,
    input  logic [N-1:0] botao,
    output logic [N-1:0] nivel,
    output logic [N-1:0] pulso_press,
    output logic [N-1:0] pulso_solta,
    output logic [N-1:0] pulso_longo
);

    // Counters share one width, large enough for the bigger of the two limits.
    localparam int MAX_TICKS = (STABLE_TICKS > LONG_TICKS) ? STABLE_TICKS : LONG_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);

    // Pin level of a released button; synchronisers reset to it so that
    // leaving reset never looks like a press edge.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ESPERA_P = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] ESPERA_S = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers and tick edge detector
    // ------------------------------------------------------------------
    logic         tick_meta_q, tick_meta_d;
    logic         tick_sync_q, tick_sync_d;
    logic         tick_prev_q, tick_prev_d;
    logic [N-1:0] botao_meta_q, botao_meta_d;
    logic [N-1:0] botao_sync_q, botao_sync_d;

    logic         tick;
    logic [N-1:0] b;

    always_comb begin
        tick_meta_d  = tick_in;
        tick_sync_d  = tick_meta_q;
        tick_prev_d  = tick_sync_q;
        botao_meta_d = botao;
        botao_sync_d = botao_meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_meta_q  <= 1'b0;
            tick_sync_q  <= 1'b0;
            tick_prev_q  <= 1'b0;
            botao_meta_q <= {N{REL_LVL}};
            botao_sync_q <= {N{REL_LVL}};
        end else begin
            tick_meta_q  <= tick_meta_d;
            tick_sync_q  <= tick_sync_d;
            tick_prev_q  <= tick_prev_d;
            botao_meta_q <= botao_meta_d;
            botao_sync_q <= botao_sync_d;
        end
    end

    // Single-cycle strobe on each rising edge of the synchronised tick.
    assign tick = tick_sync_q & ~tick_prev_q;

    // Normalise polarity: 1 always means pressed from here on.
    assign b = botao_sync_q ^ {N{REL_LVL}};

    // ------------------------------------------------------------------
    // Per-button debounce / classification FSM
    // ------------------------------------------------------------------
    logic [N-1:0][1:0]    st_q, st_d;
    logic [N-1:0][CW-1:0] dc_q, dc_d;
    logic [N-1:0][CW-1:0] lc_q, lc_d;
    logic [N-1:0]         lf_q, lf_d;
    logic [N-1:0]         nivel_q, nivel_d;
    logic [N-1:0]         press_q, press_d;
    logic [N-1:0]         solta_q, solta_d;
    logic [N-1:0]         longo_q, longo_d;

    always_comb begin
        st_d    = st_q;
        dc_d    = dc_q;
        lc_d    = lc_q;
        lf_d    = lf_q;
        nivel_d = nivel_q;
        // Pulses are cleared every cycle, so each lasts exactly one clk.
        press_d = '0;
        solta_d = '0;
        longo_d = '0;

        if (tick) begin
            for (int i = 0; i < N; i++) begin
                case (st_q[i])
                    IDLE: begin
                        if (b[i]) begin
                            st_d[i] = ESPERA_P;
                            dc_d[i] = CNT_ONE;
                        end
                    end

                    ESPERA_P: begin
                        if (!b[i]) begin
                            st_d[i] = IDLE;
                            dc_d[i] = CNT_ZERO;
                        end else if (dc_q[i] + CNT_ONE == STABLE_C) begin
                            st_d[i]    = PRESSED;
                            nivel_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                            dc_d[i]    = CNT_ZERO;
                            lc_d[i]    = CNT_ZERO;
                        end else begin
                            dc_d[i] = dc_q[i] + CNT_ONE;
                        end
                    end

                    PRESSED: begin
                        if (b[i]) begin
                            // Saturate so a very long hold never wraps back
                            // into another long-press window.
                            if (lc_q[i] != LONG_C) begin
                                lc_d[i] = lc_q[i] + CNT_ONE;
                                if ((lc_q[i] + CNT_ONE == LONG_C) && !lf_q[i]) begin
                                    longo_d[i] = 1'b1;
                                    lf_d[i]    = 1'b1;
                                end
                            end
                        end else begin
                            st_d[i] = ESPERA_S;
                            dc_d[i] = CNT_ONE;
                        end
                    end

                    ESPERA_S: begin
                        if (b[i]) begin
                            // Release glitch: the hold restarts, but lf stays
                            // set so the same press cannot long-fire twice.
                            st_d[i] = PRESSED;
                            dc_d[i] = CNT_ZERO;
                            lc_d[i] = CNT_ZERO;
                        end else if (dc_q[i] + CNT_ONE == STABLE_C) begin
                            st_d[i]    = IDLE;
                            nivel_d[i] = 1'b0;
                            solta_d[i] = 1'b1;
                            lf_d[i]    = 1'b0;
                            dc_d[i]    = CNT_ZERO;
                        end else begin
                            dc_d[i] = dc_q[i] + CNT_ONE;
                        end
                    end

                    default: begin
                        st_d[i] = IDLE;
                        dc_d[i] = CNT_ZERO;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= {N{IDLE}};
            dc_q    <= '0;
            lc_q    <= '0;
            lf_q    <= '0;
            nivel_q <= '0;
            press_q <= '0;
            solta_q <= '0;
            longo_q <= '0;
        end else begin
            st_q    <= st_d;
            dc_q    <= dc_d;
            lc_q    <= lc_d;
            lf_q    <= lf_d;
            nivel_q <= nivel_d;
            press_q <= press_d;
            solta_q <= solta_d;
            longo_q <= longo_d;
        end
    end

    assign nivel       = nivel_q;
    assign pulso_press = press_q;
    assign pulso_solta = solta_q;
    assign pulso_longo = longo_q;

endmodule

// File: tb/tb_debounce_botoes.sv
// Purpose : self-checking bench for debounce_botoes with a tick-level model.
// Latency : each bench tick spans 8 clk; outputs are expected before the next.
// Backpr. : none; monitor pops an expected entry whenever a pulse appears.

module tb_debounce_botoes;

    localparam int NB   = 4;
    localparam int STAB = 4;
    localparam int LONG = 64;

    logic          clk;
    logic          reset;
    logic          tick_in;
    logic [NB-1:0] botao;
    logic [NB-1:0] nivel;
    logic [NB-1:0] pulso_press;
    logic [NB-1:0] pulso_solta;
    logic [NB-1:0] pulso_longo;

    debounce_botoes #(
        .N            (NB),
        .STABLE_TICKS (STAB),
        .LONG_TICKS   (LONG),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .botao       (botao),
        .nivel       (nivel),
        .pulso_press (pulso_press),
        .pulso_solta (pulso_solta),
        .pulso_longo (pulso_longo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic [NB-1:0] press;
        logic [NB-1:0] solta;
        logic [NB-1:0] longo;
        logic [NB-1:0] nivel;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // Reference model, one record per button, expressed in tick numbers:
    //   lvl    accepted level
    //   run    consecutive ticks whose sample disagreed with lvl
    //   anchor tick since which the button has been continuously held
    //   fired  long pulse already given for the current press
    bit lvl    [NB];
    int run    [NB];
    int anchor [NB];
    bit fired  [NB];

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            lvl[i]    = 1'b0;
            run[i]    = 0;
            anchor[i] = 0;
            fired[i]  = 1'b0;
        end
    endtask

    function automatic logic [NB-1:0] model_level();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = lvl[i];
        return v;
    endfunction

    task automatic model_step(input logic [NB-1:0] pins);
        exp_t e;
        bit   s;
        e.t     = tick_no;
        e.press = '0;
        e.solta = '0;
        e.longo = '0;
        for (int i = 0; i < NB; i++) begin
            s = ~pins[i];
            if (s != lvl[i]) begin
                run[i]++;
                if (run[i] == STAB) begin
                    lvl[i] = s;
                    run[i] = 0;
                    if (s) begin
                        e.press[i] = 1'b1;
                        anchor[i]  = tick_no;
                    end else begin
                        e.solta[i] = 1'b1;
                        fired[i]   = 1'b0;
                    end
                end
            end else begin
                // An aborted release restarts the hold measurement here.
                if (run[i] != 0 && lvl[i]) anchor[i] = tick_no;
                run[i] = 0;
                if (lvl[i] && !fired[i] && (tick_no - anchor[i] == LONG)) begin
                    e.longo[i] = 1'b1;
                    fired[i]   = 1'b1;
                end
            end
        end
        e.nivel = model_level();
        if (|{e.press, e.solta, e.longo}) exp_q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({nivel, pulso_press, pulso_solta, pulso_longo} != '0) begin
            errors++;
            $display("FAIL %s: nivel=%b press=%b solta=%b longo=%b, required all 0",
                     name, nivel, pulso_press, pulso_solta, pulso_longo);
        end
    endtask

    // One tick: pins settle for 4 clk, tick_in high 4 clk, then low again.
    task automatic do_tick(input logic [NB-1:0] pins);
        logic [NB-1:0] lv;
        botao = pins;
        repeat (4) @(posedge clk);
        #1;
        tick_in = 1'b1;
        tick_no++;
        if (reset) model_step(pins);
        repeat (4) @(posedge clk);
        #1;
        tick_in = 1'b0;
        if (reset) begin
            lv = model_level();
            checks++;
            if (nivel !== lv) begin
                errors++;
                $display("FAIL nivel tick %0d: got %b, required %b", tick_no, nivel, lv);
            end
        end else begin
            check_zero("reset_hold");
        end
    endtask

    task automatic repeat_ticks(input logic [NB-1:0] pins, input int n);
        for (int k = 0; k < n; k++) do_tick(pins);
    endtask

    // Monitor: any pulse must match the oldest expected event and its tick.
    always @(negedge clk) begin
        exp_t e;
        if (|{pulso_press, pulso_solta, pulso_longo}) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse tick %0d: press=%b solta=%b longo=%b",
                         tick_no, pulso_press, pulso_solta, pulso_longo);
            end else begin
                e = exp_q.pop_front();
                if (e.t != tick_no || pulso_press !== e.press || pulso_solta !== e.solta ||
                    pulso_longo !== e.longo || nivel !== e.nivel) begin
                    errors++;
                    $display("FAIL pulse_event: got tick %0d p=%b s=%b l=%b n=%b, required tick %0d p=%b s=%b l=%b n=%b",
                             tick_no, pulso_press, pulso_solta, pulso_longo, nivel,
                             e.t, e.press, e.solta, e.longo, e.nivel);
                end
            end
        end
    end

    initial begin
        logic [NB-1:0] pins;
        clk     = 1'b0;
        reset   = 1'b1;
        tick_in = 1'b0;
        botao   = '1;
        model_reset();
        #2 reset = 1'b0;
        #1 check_zero("reset_initial");

        // Reset held with all buttons pressed and ticks running.
        repeat_ticks(4'b0000, 5);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        repeat_ticks(4'b0000, 6);   // all four press on the 4th tick
        repeat_ticks(4'b1111, 6);   // all four release on the 4th tick

        // Clean press/release on button 2.
        repeat_ticks(4'b1011, 10);
        repeat_ticks(4'b1111, 6);

        // Press bounce on button 0: never four agreeing ticks.
        do_tick(4'b1111);
        do_tick(4'b1110);
        do_tick(4'b1111);
        repeat_ticks(4'b1110, 3);
        repeat_ticks(4'b1111, 3);
        // Release bounce while button 0 is held.
        repeat_ticks(4'b1110, 6);
        do_tick(4'b1111);
        do_tick(4'b1110);
        repeat_ticks(4'b1111, 3);
        repeat_ticks(4'b1110, 3);
        repeat_ticks(4'b1111, 6);

        // Long press on button 1, then a 2-tick release glitch and a second
        // long hold that must not fire again.
        repeat_ticks(4'b1101, 80);
        repeat_ticks(4'b1111, 2);
        repeat_ticks(4'b1101, 70);
        repeat_ticks(4'b1111, 6);

        // Buttons 0 and 3 pressed on the same tick.
        repeat_ticks(4'b0110, 6);
        repeat_ticks(4'b1111, 6);

        // Reset while button 1 is in the release-debounce window.
        repeat_ticks(4'b1101, 5);
        repeat_ticks(4'b1111, 2);
        reset = 1'b0;
        #1 check_zero("reset_mid_op");
        repeat_ticks(4'b1111, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        repeat_ticks(4'b1101, 5);   // restarts from idle: press on 4th tick
        repeat_ticks(4'b1111, 6);

        // Random phase: each pin flips with probability 1/4 per tick.
        pins = '1;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 3) == 0) pins[i] = ~pins[i];
            do_tick(pins);
        end
        repeat_ticks(4'b1111, 6);

        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected events never seen, required 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
